// File: rtl/tetris_board.sv
// rtl/tetris_board.sv - playfield engine: tile offer, drop, write, line clear (TETRIS_BOARD_LINE_CLEAR_EN)
module tetris_board #(
  parameter int         ROWS = 20,
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  output logic        host_ready,
  input  logic        player_ready,
  output logic [3:0]  tile_type,
  input  logic        row_req,
  input  logic [5:0]  row,
  output logic [9:0]  row_info,
  input  logic [3:0]  col,
  input  logic [1:0]  rotation,
  input  logic        set_tile,
  output logic        game_over,
  output logic        bad_move,
  output logic [15:0] lines_cleared
);

  typedef enum logic [2:0] {OFFER, CHECK, DROP, WRITE, CLEAR, OVER} state_t;
  state_t state_q, state_d;

  logic [9:0] board   [ROWS];
  logic [9:0] board_d [ROWS];
  logic [7:0] lfsr_q, lfsr_nx;
  logic [2:0] tile_q;
  logic [3:0] col_q;
  logic [1:0] rot_q;
  logic [5:0] base_q, probe;
  logic [15:0] shape;
  logic [2:0] w, h;
  logic [9:0] srow [4];
  logic [9:0] rd_row;
  logic too_wide, collide, load_next;

  function automatic logic [2:0] map_tile(input logic [2:0] t);
    return (t == 3'd7) ? 3'd0 : t;
  endfunction

  // Mask bit 4*y+x is cell (column x, row y), row 0 at the bottom.
  function automatic logic [15:0] base_shape(input logic [2:0] t);
    case (t)
      3'd0:    return 16'h000F;
      3'd1:    return 16'h0033;
      3'd2:    return 16'h0027;
      3'd3:    return 16'h0063;
      3'd4:    return 16'h0036;
      3'd5:    return 16'h0017;
      default: return 16'h0047;
    endcase
  endfunction

  // Clockwise turn (x,y) -> (y,3-x), then slide the shape to the bottom-left corner.
  function automatic logic [15:0] rot_cw(input logic [15:0] m);
    logic [15:0] t;
    t = '0;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        if (m[4*y+x]) t[4*(3-x)+y] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (t[3:0] == 4'h0) t = t >> 4;
      if ((t & 16'h1111) == 16'h0) t = (t >> 1) & 16'h7777;
    end
    return t;
  endfunction

  always_comb begin
    shape = base_shape(tile_q);
    for (int i = 0; i < 3; i++)
      if (2'(i) < rot_q) shape = rot_cw(shape);
    w = '0;
    h = '0;
    for (int k = 0; k < 4; k++) begin
      if (shape[4*k +: 4] != 4'h0) h = 3'(k + 1);
      if ((shape & (16'h1111 << k)) != 16'h0) w = 3'(k + 1);
    end
    for (int j = 0; j < 4; j++)
      srow[j] = 10'({10'b0, shape[4*j +: 4]} << col_q);
  end

  assign too_wide = ({1'b0, col_q} + {2'b0, w}) > 5'd10;
  assign lfsr_nx  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // CHECK probes the spawn position, DROP probes one row below the candidate.
  always_comb begin
    probe   = (state_q == CHECK) ? 6'(ROWS) - {3'b0, h} : base_q - 6'd1;
    collide = 1'b0;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < ROWS; k++)
        if (3'(j) < h && ({1'b0, probe} + 7'(j)) == 7'(k))
          collide = collide | (|(board[k] & srow[j]));
  end

  always_comb begin
    rd_row = '0;
    for (int k = 0; k < ROWS; k++)
      if (row == 6'(k)) rd_row = board[k];
  end

`ifdef TETRIS_BOARD_LINE_CLEAR_EN
  logic [5:0]  scan_q;
  logic [9:0]  scan_row;
  logic        row_full;
  logic [15:0] lines_q;

  always_comb begin
    scan_row = '0;
    for (int k = 0; k < ROWS; k++)
      if (scan_q == 6'(k)) scan_row = board[k];
  end
  assign row_full      = (scan_row == 10'h3FF);
  assign lines_cleared = lines_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_q  <= '0;
      lines_q <= '0;
    end else if (state_q == WRITE) begin
      scan_q <= '0;
    end else if (state_q == CLEAR) begin
      if (row_full) lines_q <= lines_q + 16'd1;
      else          scan_q  <= scan_q + 6'd1;
    end
  end
`else
  assign lines_cleared = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= OFFER;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_next = 1'b0;
    case (state_q)
      OFFER: if (player_ready && set_tile) state_d = CHECK;
      CHECK: begin
        if (too_wide)     state_d = OFFER;
        else if (collide) state_d = OVER;
        else              state_d = DROP;
      end
      DROP: if (base_q == 6'd0 || collide) state_d = WRITE;
`ifdef TETRIS_BOARD_LINE_CLEAR_EN
      WRITE: state_d = CLEAR;
      CLEAR: begin
        if (!row_full && scan_q == 6'(ROWS - 1)) begin
          state_d   = OFFER;
          load_next = 1'b1;
        end
      end
`else
      WRITE: begin
        state_d   = OFFER;
        load_next = 1'b1;
      end
`endif
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    host_ready = (state_q == OFFER);
    game_over  = (state_q == OVER);
    bad_move   = (state_q == CHECK) && too_wide;
  end

  assign tile_type = {1'b0, tile_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= SEED;
      tile_q <= map_tile(SEED[2:0]);
      col_q  <= '0;
      rot_q  <= '0;
      base_q <= '0;
    end else begin
      if (state_q == OFFER && player_ready && set_tile) begin
        col_q <= col;
        rot_q <= rotation;
      end
      if (state_q == CHECK)
        base_q <= 6'(ROWS) - {3'b0, h};
      else if (state_q == DROP && state_d == DROP)
        base_q <= base_q - 6'd1;
      if (load_next) begin
        lfsr_q <= lfsr_nx;
        tile_q <= map_tile(lfsr_nx[2:0]);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < ROWS; k++) board_d[k] = board[k];
    if (state_q == WRITE) begin
      for (int k = 0; k < ROWS; k++)
        for (int j = 0; j < 4; j++)
          if (3'(j) < h && ({1'b0, base_q} + 7'(j)) == 7'(k))
            board_d[k] = board_d[k] | srow[j];
    end
`ifdef TETRIS_BOARD_LINE_CLEAR_EN
    // A full row collapses everything above it in one cycle; the top row refills with zeros.
    if (state_q == CLEAR && row_full) begin
      for (int k = 0; k < ROWS - 1; k++)
        if (6'(k) >= scan_q) board_d[k] = board[k+1];
      board_d[ROWS-1] = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < ROWS; k++) board[k] <= '0;
    end else begin
      for (int k = 0; k < ROWS; k++) board[k] <= board_d[k];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       row_info <= '0;
    else if (row_req) row_info <= rd_row;
  end

endmodule

// File: tb/tb_tetris_board.sv
// tb/tb_tetris_board.sv - directed self-checking bench for tetris_board
module tb_tetris_board;
  localparam int ROWS = 20;
`ifdef TETRIS_BOARD_LINE_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_ready;
  logic        player_ready = 1'b0;
  logic [3:0]  tile_type;
  logic        row_req = 1'b0;
  logic [5:0]  row = '0;
  logic [9:0]  row_info;
  logic [3:0]  col = '0;
  logic [1:0]  rotation = '0;
  logic        set_tile = 1'b0;
  logic        game_over;
  logic        bad_move;
  logic [15:0] lines_cleared;

  int checks = 0;
  int failures = 0;
  int n;
  int exp_tiles [7] = '{4, 1, 3, 0, 6, 5, 3};

  tetris_board #(.ROWS(ROWS), .SEED(8'hA5)) dut (
    .clk(clk), .reset(reset), .host_ready(host_ready), .player_ready(player_ready),
    .tile_type(tile_type), .row_req(row_req), .row(row), .row_info(row_info),
    .col(col), .rotation(rotation), .set_tile(set_tile), .game_over(game_over),
    .bad_move(bad_move), .lines_cleared(lines_cleared)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_row(input int r, input logic [9:0] exp, input string tag);
    row_req = 1'b1;
    row = 6'(r);
    tick();
    row_req = 1'b0;
    check(tag, 32'(row_info), 32'(exp));
  endtask

  task automatic accept(input logic [3:0] c, input logic [1:0] rt);
    player_ready = 1'b1;
    set_tile = 1'b1;
    col = c;
    rotation = rt;
    tick();
    player_ready = 1'b0;
    set_tile = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int nout);
    nout = n0;
    while (!host_ready && !game_over && nout < 300) begin
      tick();
      nout++;
    end
  endtask

  initial begin
    #2 reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("rst_host_ready", 32'(host_ready), 32'd1);
    check("rst_tile", 32'(tile_type), 32'd5);
    check("rst_game_over", 32'(game_over), 32'd0);
    check("rst_bad_move", 32'(bad_move), 32'd0);
    check("rst_lines", 32'(lines_cleared), 32'd0);
    check("rst_row_info", 32'(row_info), 32'd0);
    for (int i = 0; i < ROWS; i++) begin
      row_req = 1'b1;
      row = 6'(i);
      tick();
      check($sformatf("rst_row%0d", i), 32'(row_info), 32'd0);
    end
    row_req = 1'b0;
    read_row(20, 10'h000, "row_oob20");
    read_row(63, 10'h000, "row_oob63");

    // J rot0 at col 8 is one column too wide
    accept(4'd8, 2'd0);
    check("bad_j_pulse", 32'(bad_move), 32'd1);
    check("bad_j_busy", 32'(host_ready), 32'd0);
    wait_done(0, n);
    check("bad_j_lat", 32'(n), 32'd1);
    check("bad_j_pulse_end", 32'(bad_move), 32'd0);
    check("bad_j_same_tile", 32'(tile_type), 32'd5);
    read_row(0, 10'h000, "bad_j_row0");

    // J rot0 at col 0; a set_tile mid-move must be ignored
    accept(4'd0, 2'd0);
    n = 0;
    repeat (3) begin
      tick();
      n++;
    end
    check("j0_busy", 32'(host_ready), 32'd0);
    player_ready = 1'b1;
    set_tile = 1'b1;
    col = 4'd5;
    tick();
    n++;
    player_ready = 1'b0;
    set_tile = 1'b0;
    wait_done(n, n);
    check("j0_lat", 32'(n), CLR ? 32'd41 : 32'd21);
    check("j0_next_tile", 32'(tile_type), 32'd2);
    read_row(0, 10'h007, "j0_row0");
    read_row(2, 10'h000, "j0_row2");
    read_row(1, 10'h001, "j0_row1");
    row = 6'd0;
    tick();
    check("row_info_hold", 32'(row_info), 32'h001);

    // T: reject at col 8, then rot0 at col 3
    accept(4'd8, 2'd0);
    check("bad_t_pulse", 32'(bad_move), 32'd1);
    wait_done(0, n);
    check("bad_t_lat", 32'(n), 32'd1);
    check("bad_t_same_tile", 32'(tile_type), 32'd2);
    accept(4'd3, 2'd0);
    wait_done(0, n);
    check("t3_lat", 32'(n), CLR ? 32'd41 : 32'd21);
    read_row(0, 10'h03F, "t3_row0");
    read_row(1, 10'h011, "t3_row1");
    check("t3_next_tile", 32'(tile_type), 32'd5);

    accept(4'd6, 2'd0);
    wait_done(0, n);
    check("j6_lat", 32'(n), CLR ? 32'd41 : 32'd21);
    read_row(0, 10'h1FF, "j6_row0");
    read_row(1, 10'h051, "j6_row1");
    check("j6_next_tile", 32'(tile_type), 32'd2);

    // T rot3 (width 2): col 9 rejected, col 8 fits and completes row 0
    accept(4'd9, 2'd3);
    check("bad_t9_pulse", 32'(bad_move), 32'd1);
    wait_done(0, n);
    check("bad_t9_same_tile", 32'(tile_type), 32'd2);
    accept(4'd8, 2'd3);
    wait_done(0, n);
    check("t8_lat", 32'(n), CLR ? 32'd41 : 32'd20);
    read_row(0, CLR ? 10'h351 : 10'h3FF, "clr_row0");
    read_row(1, CLR ? 10'h200 : 10'h351, "clr_row1");
    read_row(2, CLR ? 10'h000 : 10'h200, "clr_row2");
    check("clr_lines", 32'(lines_cleared), CLR ? 32'd1 : 32'd0);
    check("clr_next_tile", 32'(tile_type), 32'd4);

    // Stack rot1 tiles at col 0: Z O S I L J land, the next S collides at spawn
    for (int i = 0; i < 7; i++) begin
      check($sformatf("stack_tile%0d", i), 32'(tile_type), exp_tiles[i]);
      accept(4'd0, 2'd1);
      wait_done(0, n);
      check($sformatf("stack_over%0d", i), 32'(game_over), (i == 6) ? 32'd1 : 32'd0);
      check($sformatf("stack_ready%0d", i), 32'(host_ready), (i == 6) ? 32'd0 : 32'd1);
    end
    check("over_lat", 32'(n), 32'd1);
    player_ready = 1'b1;
    set_tile = 1'b1;
    col = 4'd5;
    rotation = 2'd0;
    repeat (5) tick();
    player_ready = 1'b0;
    set_tile = 1'b0;
    check("over_sticky", 32'(game_over), 32'd1);
    check("over_not_ready", 32'(host_ready), 32'd0);
    check("over_no_bad", 32'(bad_move), 32'd0);
    read_row(18, CLR ? 10'h003 : 10'h001, "over_row18");
    read_row(19, CLR ? 10'h000 : 10'h003, "over_row19");
    read_row(0, CLR ? 10'h351 : 10'h3FF, "over_row0");
    check("over_lines", 32'(lines_cleared), CLR ? 32'd1 : 32'd0);

    // Asynchronous reset out of OVER, mid-cycle
    #3 reset = 1'b0;
    #1;
    check("areset_row_info", 32'(row_info), 32'd0);
    check("areset_game_over", 32'(game_over), 32'd0);
    check("areset_ready", 32'(host_ready), 32'd1);
    check("areset_tile", 32'(tile_type), 32'd5);
    check("areset_lines", 32'(lines_cleared), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Reset while the tile is dropping
    accept(4'd0, 2'd0);
    repeat (4) tick();
    check("drop_busy", 32'(host_ready), 32'd0);
    #3 reset = 1'b0;
    #1;
    check("drop_rst_ready", 32'(host_ready), 32'd1);
    check("drop_rst_game_over", 32'(game_over), 32'd0);
    check("drop_rst_bad", 32'(bad_move), 32'd0);
    check("drop_rst_tile", 32'(tile_type), 32'd5);
    check("drop_rst_lines", 32'(lines_cleared), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < ROWS; i++) begin
      row_req = 1'b1;
      row = 6'(i);
      tick();
      check($sformatf("drop_rst_row%0d", i), 32'(row_info), 32'd0);
    end
    row_req = 1'b0;
    check("drop_rst_ready_after", 32'(host_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
